cache_mem_arbiter: RTL

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache miss requests onto a single memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: I-cache wins).
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] i_a,
    input  logic              i_strobe,
    output logic [DATA_W-1:0] i_dout,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_a,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wen,
    input  logic [DATA_W-1:0] d_din,
    output logic [DATA_W-1:0] d_dout,
    output logic              d_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_access,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_st_data,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic              grant_d;      // 1 = current transaction belongs to the D-cache
    logic              pick_d;       // side that would be granted this IDLE cycle
    logic              drop;
    logic              grant_strobe;
    logic [ADDR_W-1:0] lat_a;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic [3:0]        lat_sel;
    logic [DATA_W-1:0] lat_st_data;
    logic [DATA_W-1:0] i_data_q;
    logic [DATA_W-1:0] d_data_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    always_comb begin
        if (i_strobe && d_strobe) pick_d = !last_d;
        else                      pick_d = d_strobe;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_d <= 1'b1;
        else if (state == IDLE && (i_strobe || d_strobe))
            last_d <= pick_d;
    end
`else
    assign pick_d = d_strobe && !i_strobe;
`endif

    assign grant_strobe = grant_d ? d_strobe : i_strobe;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // NOTE: next state gets a default first so no path through this block infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_strobe || d_strobe) state_nx = BUSY;
            BUSY:    if (mem_ready)            state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request fields are frozen at grant so the bus sees nothing the caches do afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_d     <= 1'b0;
            lat_a       <= '0;
            lat_write   <= 1'b0;
            lat_size    <= 2'b00;
            lat_sel     <= 4'b0000;
            lat_st_data <= '0;
        end else if (state == IDLE && (i_strobe || d_strobe)) begin
            grant_d <= pick_d;
            if (pick_d) begin
                lat_a       <= d_a;
                lat_write   <= d_rw;
                lat_size    <= d_size;
                lat_sel     <= d_wen;
                lat_st_data <= d_din;
            end else begin
                lat_a       <= i_a;
                lat_write   <= 1'b0;
                lat_size    <= 2'b10;
                lat_sel     <= 4'b1111;
                lat_st_data <= '0;
            end
        end
    end

    // A grantee that lets go of its strobe mid-transaction no longer wants the answer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            drop <= 1'b0;
        else if (state == IDLE)
            drop <= 1'b0;
        else if (state == BUSY && !grant_strobe)
            drop <= 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_data_q <= '0;
            d_data_q <= '0;
        end else if (state == BUSY && mem_ready) begin
            if (grant_d) d_data_q <= mem_data;
            else         i_data_q <= mem_data;
        end
    end

    assign mem_access  = (state == BUSY);
    assign mem_a       = lat_a;
    assign mem_write   = lat_write;
    assign mem_size    = lat_size;
    assign mem_sel     = lat_sel;
    assign mem_st_data = lat_st_data;

    assign i_ready = (state == RESP) && !grant_d && !drop;
    assign d_ready = (state == RESP) &&  grant_d && !drop;
    assign i_dout  = i_data_q;
    assign d_dout  = d_data_q;

endmodule
